// File: rtl/octree_child_expander.sv
// Pops packed octree nodes from a registered-read FIFO and streams one child-address
// request per occupied octant. Define OCTREE_EXPAND_STATS_EN to build the node/leaf counters.
module octree_child_expander #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = ADDR_WIDTH + 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [2:0]            out_idx,
  output logic                  out_last,
  output logic                  busy,
  output logic [31:0]           stat_nodes,
  output logic [31:0]           stat_leaf,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [7:0]            mask_q;
  logic [2:0]            rank_q;
  logic [7:0]            rd_mask;

  assign rd_mask = fifo_rdata[7:0];

  // Output stream: a beat transfers on a cycle where out_valid && out_ready. Once
  // out_valid rises, it and out_addr/out_idx/out_last hold until that transfer.
  assign out_valid = (state == EMIT);
  assign out_last  = (mask_q != 8'd0) && ((mask_q & (mask_q - 8'd1)) == 8'd0);
  assign out_addr  = base_q + {{(ADDR_WIDTH-3){1'b0}}, rank_q};
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Next node is fetched from IDLE, or overlapped with the last-child transfer.
  assign fifo_rd_en = !fifo_empty &&
                      ((state == IDLE) || ((state == EMIT) && out_ready && out_last));

  always_comb begin
    out_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i]) out_idx = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      base_q <= '0;
      mask_q <= '0;
      rank_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) state <= WAIT;
        end
        WAIT: begin
          base_q <= fifo_rdata[DATA_WIDTH-1:8];
          mask_q <= rd_mask;
          rank_q <= '0;
          state  <= (rd_mask == 8'd0) ? IDLE : EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            mask_q <= mask_q & (mask_q - 8'd1);
            rank_q <= rank_q + 3'd1;
            if (out_last) state <= fifo_empty ? IDLE : WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OCTREE_EXPAND_STATS_EN
  logic [31:0] nodes_q;
  logic [31:0] leaf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nodes_q <= '0;
      leaf_q  <= '0;
    end else if (state == WAIT) begin
      nodes_q <= nodes_q + 32'd1;
      if (rd_mask == 8'd0) leaf_q <= leaf_q + 32'd1;
    end
  end

  assign stat_nodes = nodes_q;
  assign stat_leaf  = leaf_q;
`else
  assign stat_nodes = 32'd0;
  assign stat_leaf  = 32'd0;
`endif

endmodule

// File: doc/octree_child_expander.md
# octree_child_expander

Downstream consumer of the octree traversal node FIFO. Pops one packed node descriptor at a time, honouring the FIFO's one-cycle registered read, and expands its 8-bit child-occupancy mask into a sequence of child-address requests on a valid/ready stream. Children are stored contiguously, so the child address is the node base plus the child's rank among occupied octants. The output feeds the node-fetch stage.

## Interface
- ADDR_WIDTH, 16, width of node base address and child address
- DATA_WIDTH, ADDR_WIDTH+8, FIFO word width; layout {base_addr[ADDR_WIDTH-1:0], child_mask[7:0]}
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO read strobe
- fifo_rdata  in  DATA_WIDTH  FIFO read data; valid the cycle after fifo_rd_en
- out_valid  out  1  child request valid
- out_ready  in  1  downstream accepts
- out_addr  out  ADDR_WIDTH  child address
- out_idx  out  3  octant index 0..7 of this child
- out_last  out  1  final child of the current node
- busy  out  1  node held or read in flight (state != IDLE)
- stat_nodes  out  32  nodes popped (see Configuration)
- stat_leaf  out  32  nodes popped with mask 0 (see Configuration)

## Operation
- FSM states: IDLE, WAIT, EMIT.
- IDLE: if !fifo_empty, assert fifo_rd_en for one cycle, go WAIT.
- WAIT: capture fifo_rdata into base/mask registers, clear rank to 0. If mask == 0, drop the node (no output) and go IDLE. Otherwise go EMIT.
- EMIT: out_valid = 1. out_idx = index of the lowest set bit of the remaining mask. out_addr = base + rank, where rank is the count of children already emitted for this node. out_last = 1 when exactly one bit remains.
- EMIT handshake: on out_valid && out_ready, clear the lowest set bit and increment rank.
- Last child accepted, !fifo_empty: assert fifo_rd_en in the same cycle and go WAIT. This gives back-to-back nodes with one bubble.
- Last child accepted, fifo_empty: go IDLE.
- Children are emitted in ascending octant order.
- out_addr is computed modulo 2^ADDR_WIDTH; wrap-around is silent.
- fifo_rd_en is never asserted while fifo_empty = 1. It is never asserted in WAIT, or in EMIT except on the last-child handshake.
- While out_valid && !out_ready, out_addr, out_idx and out_last hold stable.
- out_valid never drops without a handshake.

## Timing
- Reset values: fifo_rd_en 0, out_valid 0, out_addr 0, out_idx 0, out_last 0, busy 0, stat_nodes 0, stat_leaf 0. FSM resets to IDLE.
- Assertion of rst_n mid-operation discards the held node and any in-flight read immediately.
- Latency from !fifo_empty in IDLE (cycle t):
  - fifo_rd_en asserted at t.
  - Data captured at edge t+1.
  - out_valid first high in cycle t+2.
- Throughput with out_ready held high: one child per cycle. Each node costs popcount(mask) + 1 cycles. A mask-0 node costs 2 cycles.
- out_* outputs are registered or derived only from registered state; there is no combinational path from out_ready to out_valid.
- fifo_rd_en is combinational from state, fifo_empty and out_ready.

## Configuration
- OCTREE_EXPAND_STATS_EN defined:
  - stat_nodes increments on every WAIT capture.
  - stat_leaf increments on every WAIT capture with mask == 0.
  - Both counters are 32-bit and wrap at 2^32.
- Not defined: the counter registers are not built, and stat_nodes and stat_leaf are tied to 0. Ports remain present. All other behaviour is identical.

## Test plan
- Single node {base 0x0100, mask 0xA5}, out_ready = 1 -> four beats:
  - (0x0100, idx 0), (0x0101, idx 2), (0x0102, idx 5), (0x0103, idx 7, last).
  - First valid 2 cycles after the read.
- Node mask 0x00 followed by {base 0x0200, mask 0x80}:
  - The first node produces no output.
  - Then a single beat (0x0200, idx 7, last).
  - stat_leaf = 1 and stat_nodes = 2 when stats are enabled.
- Backpressure: {base 0x0010, mask 0x03}, out_ready low for 5 cycles on the first beat -> (0x0010, idx 0) held stable, then (0x0011, idx 1, last).
- Wrap: {base 0xFFFF, mask 0x06} -> (0xFFFF, idx 1), then (0x0000, idx 2, last).
- Three queued full nodes (mask 0xFF), out_ready = 1:
  - 24 beats total with exactly one bubble between nodes.
  - Exactly 3 fifo_rd_en pulses, none while fifo_empty.
- rst_n asserted during EMIT after the second of 8 children:
  - out_valid drops to 0 immediately; the FSM is in IDLE and busy = 0.
  - After release, the next FIFO node is expanded from its first child.
